// File: rtl/sun_sprite_core.sv
// sun_sprite_core: overlays a 32x32 paletted sun sprite on the video stream and owns its bus registers.
// Define SUN_ANIM_EN to swap palette entries 2 and 3 every ANIM_FRAMES frames.
module sun_sprite_core #(
  parameter int CD          = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 2,
  parameter int ANIM_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_start,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb,
  input  logic                  wr_en,
  input  logic [10:0]           wr_addr,
  input  logic [31:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);
  localparam int HW = ADDR_WIDTH / 2;
  localparam logic [11:0] SIZE = 12'(1 << HW);
  logic [10:0] x0_pend_q, y0_pend_q, x0_q, y0_q;
  logic en_q, in_q, ram_we_q, swap, in_region, unused;
  logic [CD-1:0] pal1_q, pal2_q, pal3_q, rgb_q, so_q, so_d, pal;
  logic [ADDR_WIDTH-1:0] ram_addr_w_q;
  logic [DATA_WIDTH-1:0] ram_din_q, idx;
  logic [11:0] xe, ye, x0e, y0e, dx, dy;
  // 12-bit arithmetic keeps x0+32 from wrapping when x0 sits near 2047
  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y};
    x0e = {1'b0, x0_q};
    y0e = {1'b0, y0_q};
    dx = xe - x0e;
    dy = ye - y0e;
    in_region = (xe >= x0e) && (xe < x0e + SIZE) && (ye >= y0e) && (ye < y0e + SIZE);
    idx = (swap && ram_dout[1]) ? {1'b1, ~ram_dout[0]} : ram_dout;
    pal = (idx == 2'd1) ? pal1_q : (idx == 2'd2) ? pal2_q : pal3_q;
    so_d = (in_q && en_q && |ram_dout) ? pal : rgb_q;
  end
  assign ram_addr_r = {dy[HW-1:0], dx[HW-1:0]};
  assign so_rgb = so_q;
  assign ram_we = ram_we_q;
  assign ram_addr_w = ram_addr_w_q;
  assign ram_din = ram_din_q;
  assign unused = ^{wr_data, dx, dy};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x0_pend_q <= '0;
      y0_pend_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      en_q <= 1'b0;
      pal1_q <= CD'(12'hFF0);
      pal2_q <= CD'(12'hF80);
      pal3_q <= CD'(12'hFC0);
      in_q <= 1'b0;
      rgb_q <= '0;
      so_q <= '0;
      ram_we_q <= 1'b0;
      ram_addr_w_q <= '0;
      ram_din_q <= '0;
    end else begin
      ram_we_q <= wr_en && wr_addr[10];
      if (wr_en && wr_addr[10]) begin
        ram_addr_w_q <= wr_addr[ADDR_WIDTH-1:0];
        ram_din_q <= wr_data[DATA_WIDTH-1:0];
      end
      if (wr_en && wr_addr == 11'd0) x0_pend_q <= wr_data[10:0];
      if (wr_en && wr_addr == 11'd1) y0_pend_q <= wr_data[10:0];
      if (wr_en && wr_addr == 11'd2) en_q <= wr_data[0];
      if (wr_en && wr_addr == 11'd3) pal1_q <= wr_data[CD-1:0];
      if (wr_en && wr_addr == 11'd4) pal2_q <= wr_data[CD-1:0];
      if (wr_en && wr_addr == 11'd5) pal3_q <= wr_data[CD-1:0];
      // Shadowed origin: a same-cycle write lands in pending and waits a frame
      if (frame_start) begin
        x0_q <= x0_pend_q;
        y0_q <= y0_pend_q;
      end
      in_q <= in_region;
      rgb_q <= si_rgb;
      so_q <= so_d;
    end
`ifdef SUN_ANIM_EN
  localparam int CW = $clog2(ANIM_FRAMES + 1);
  logic [CW-1:0] cnt_q;
  logic swap_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      swap_q <= 1'b0;
    end else if (frame_start) begin
      cnt_q <= (cnt_q == CW'(ANIM_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
      swap_q <= (cnt_q == CW'(ANIM_FRAMES - 1)) ? ~swap_q : swap_q;
    end
  assign swap = swap_q;
`else
  logic unused_anim;
  assign unused_anim = (ANIM_FRAMES != 0);
  assign swap = 1'b0;
`endif
endmodule

// File: doc/sun_sprite_core.md
# sun_sprite_core

Pixel-generation stage directly downstream of the sun bitmap RAM (32×32, 2-bit colour index, 1-cycle registered read). Takes the current scan coordinate, drives the RAM read address, turns the returned index into a 12-bit RGB value through a 3-entry palette, and overlays the sun on the incoming video stream. It also owns the processor-bus register file: the sprite origin, enable and palette registers, plus forwarding of bitmap writes into the RAM write port.

## Interface
- `CD`, 12: RGB colour depth (4:4:4).
- `ADDR_WIDTH`, 10: bitmap RAM address width (5 bits y, 5 bits x).
- `DATA_WIDTH`, 2: bitmap colour-index width.
- `ANIM_FRAMES`, 30: frames between palette swaps (animation only).

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `x`, `y`  in  11 each: current scan coordinate.
- `frame_start`  in  1: one-cycle pulse at the start of each frame.
- `si_rgb`  in  CD: upstream video pixel.
- `so_rgb`  out  CD: output pixel, delayed 2 cycles from `x`/`y`/`si_rgb`.
- `wr_en`  in  1: bus write strobe.
- `wr_addr`  in  11: bus word address.
- `wr_data`  in  32: bus write data.
- `ram_addr_r`  out  ADDR_WIDTH: RAM read address, combinational from `x`/`y`.
- `ram_dout`  in  DATA_WIDTH: RAM read data, valid one cycle after the address.
- `ram_we`  out  1: registered RAM write enable.
- `ram_addr_w`  out  ADDR_WIDTH: registered RAM write address.
- `ram_din`  out  DATA_WIDTH: registered RAM write data.

## Operation
- Bus map, by `wr_addr`:
  - bit 10 = 1: bitmap write, forwarded as `ram_addr_w = wr_addr[9:0]` and `ram_din = wr_data[1:0]`.
  - 0: pending x0 (`wr_data[10:0]`).
  - 1: pending y0.
  - 2: ctrl; bit0 is enable and takes effect immediately.
  - 3, 4, 5: palette entries for indices 1, 2, 3 (`wr_data[11:0]`).
  - Other addresses are ignored.
- Origin shadowing: active x0/y0 load from the pending registers only on a `frame_start` cycle. A write and `frame_start` in the same cycle: the active register takes the old pending value, and the new value applies next frame.
- Region test: `dx = x - x0` and `dy = y - y0`, computed 12-bit unsigned. `in_region = (x >= x0) && (x < x0+32) && (y >= y0) && (y < y0+32)`, using 12-bit sums so that x0 near 2047 never wraps.
- `ram_addr_r = {dy[4:0], dx[4:0]}`, driven regardless of `in_region`.
- Pipeline:
  - Stage 1 registers `in_region` and `si_rgb`.
  - Stage 2 registers `so_rgb`. If stage-1 `in_region` && enable && `ram_dout != 0`, it takes `palette[ram_dout]`; otherwise it takes stage-1 `si_rgb`.
  - Index 0 is always transparent.
- Reset values:
  - `so_rgb` = 0, pipeline registers = 0, `ram_we` = 0, `ram_addr_w` = 0, `ram_din` = 0.
  - Pending and active x0/y0 = 0, enable = 0.
  - Palette: 1 = 0xFF0, 2 = 0xF80, 3 = 0xFC0.
  - Animation counter = 0, swap flag = 0.
- Reset mid-frame: the output is 0 until the pipeline refills. No `frame_start` is needed to resume pass-through.

## Timing
- Pixel latency is exactly 2 cycles, for both overlay and pass-through. Throughput is one pixel per cycle, with no stalls.
- Bitmap write: `ram_we`, `ram_addr_w` and `ram_din` appear one cycle after `wr_en`, and `ram_we` lasts one cycle.
  - A read of the same address during the write cycle returns RAM old-data behaviour; no bypass is provided.
- Register writes are visible one cycle after `wr_en`.
- Origin changes become visible at the first pixel after `frame_start`.

## Configuration
- `SUN_ANIM_EN` defined:
  - A frame counter increments on each `frame_start`.
  - When the counter reaches `ANIM_FRAMES-1`, it wraps to 0 and toggles the swap flag.
  - While the flag is set, indices 2 and 3 read each other's palette entries.
- `SUN_ANIM_EN` undefined: no counter and no flag; the palette mapping is fixed.

## Test plan
- Reset, enable = 0, `si_rgb` = 0x123 at every x/y -> `so_rgb` = 0x123 two cycles later at every pixel, and `ram_we` is never asserted.
- Write x0 = 100, y0 = 50, enable = 1, then pulse `frame_start`. Stimulus: (x, y) = (100, 50) with `ram_dout` = 1 -> `ram_addr_r` = 0 and `so_rgb` = 0xFF0 two cycles later. At (131, 81), `ram_addr_r` = 1023. At (132, 50), `si_rgb` passes through.
- In-region pixel with `ram_dout` = 0 -> `si_rgb` passes through (transparency).
- Write x0 = 200 mid-frame -> the sprite stays at 100 until the next `frame_start`. Also issue the write in the same cycle as `frame_start` -> the move happens one frame later.
- Bus write addr = 0x405, data = 3 -> one cycle later `ram_we` = 1, `ram_addr_w` = 5, `ram_din` = 3 for exactly one cycle. x0 = 2040 with x = 2047 -> in region, with no wrap to x < 8.
- `SUN_ANIM_EN` with `ANIM_FRAMES` = 2: index 2 outputs 0xF80 in frames 0–1, 0xFC0 in frames 2–3, then 0xF80 again. Asserting `reset` mid-sequence restores 0xF80.
